// File: rtl/fust_s_issue.sv
// Scalar functional-unit issue table: per-row operand readiness tracking with a
// round-robin picker feeding a registered issue slot held until the FU accepts.
module fust_s_issue #(
    parameter int NUM_FU = 4,
    parameter int OP_W   = 32,
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int TAG_W = $clog2(NUM_FU + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              row_en,
    input  logic [FU_W-1:0]   row_fu,
    input  logic [TAG_W-1:0]  row_t1,
    input  logic [TAG_W-1:0]  row_t2,
    input  logic [OP_W-1:0]   row_op,
    input  logic              wb_en,
    input  logic [TAG_W-1:0]  wb_tag,
    output logic              iss_valid,
    output logic [FU_W-1:0]   iss_fu,
    output logic [OP_W-1:0]   iss_op,
    input  logic              iss_ready,
    output logic [NUM_FU-1:0] busy,
    output logic              disp_err
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e              state_q;
    logic [NUM_FU-1:0]   busy_q, rdy1_q, rdy2_q;
    logic [OP_W-1:0]     op_q [NUM_FU];
    logic [TAG_W-1:0]    t1_q [NUM_FU];
    logic [TAG_W-1:0]    t2_q [NUM_FU];
    logic [FU_W-1:0]     rr_q;
    logic [FU_W-1:0]     iss_fu_q;
    logic [OP_W-1:0]     iss_op_q;
    logic                disp_err_q;

    logic                row_in_range;
    logic                accept;
    logic                wb_live;
    logic                handshake;
    logic                disp_rdy1, disp_rdy2;
    logic [NUM_FU-1:0]   eligible;
    logic [FU_W-1:0]     next_rr;
    logic [FU_W-1:0]     base;
    logic                sel_found;
    logic [FU_W-1:0]     sel_idx;

    assign row_in_range = int'(row_fu) < NUM_FU;
    assign accept       = row_en & row_in_range & ~busy_q[row_fu];
    assign wb_live      = wb_en & (wb_tag != '0);
    assign handshake    = (state_q == StHold) & iss_ready;
    // A producer completing in the dispatch cycle must not be missed by the new row.
    assign disp_rdy1    = (row_t1 == '0) | (wb_live & (wb_tag == row_t1));
    assign disp_rdy2    = (row_t2 == '0) | (wb_live & (wb_tag == row_t2));
    assign next_rr      = FU_W'((int'(iss_fu_q) + 1) % NUM_FU);
    assign base         = (state_q == StHold) ? next_rr : rr_q;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            eligible[i] = busy_q[i] & rdy1_q[i] & rdy2_q[i]
                        & ~((state_q == StHold) & (int'(iss_fu_q) == i));
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(base) + k) % NUM_FU;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_idx   = FU_W'(idx);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            busy_q     <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            rr_q       <= '0;
            iss_fu_q   <= '0;
            iss_op_q   <= '0;
            disp_err_q <= 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                op_q[i] <= '0;
                t1_q[i] <= '0;
                t2_q[i] <= '0;
            end
        end else begin
            disp_err_q <= row_en & ~accept;

            for (int i = 0; i < NUM_FU; i++) begin
                if (wb_live && busy_q[i]) begin
                    if (t1_q[i] == wb_tag) rdy1_q[i] <= 1'b1;
                    if (t2_q[i] == wb_tag) rdy2_q[i] <= 1'b1;
                end
            end

            if (accept) begin
                busy_q[row_fu] <= 1'b1;
                op_q[row_fu]   <= row_op;
                t1_q[row_fu]   <= row_t1;
                t2_q[row_fu]   <= row_t2;
                rdy1_q[row_fu] <= disp_rdy1;
                rdy2_q[row_fu] <= disp_rdy2;
            end

            unique case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        state_q  <= StHold;
                        iss_fu_q <= sel_idx;
                        iss_op_q <= op_q[sel_idx];
                    end
                end
                StHold: begin
                    if (handshake) begin
                        busy_q[iss_fu_q] <= 1'b0;
                        rdy1_q[iss_fu_q] <= 1'b0;
                        rdy2_q[iss_fu_q] <= 1'b0;
                        rr_q             <= next_rr;
                        if (sel_found) begin
                            iss_fu_q <= sel_idx;
                            iss_op_q <= op_q[sel_idx];
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign iss_valid = (state_q == StHold);
    assign iss_fu    = iss_fu_q;
    assign iss_op    = iss_op_q;
    assign busy      = busy_q;
    assign disp_err  = disp_err_q;

endmodule

// File: tb/tb_fust_s_issue.sv
// Directed bench for fust_s_issue: a cycle-level behavioural model checked every cycle,
// plus literal expectations at the points the scenarios call out.
module tb_fust_s_issue;

    localparam int NUM_FU = 4;
    localparam int OP_W   = 32;
    localparam int FU_W   = 2;
    localparam int TAG_W  = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              row_en;
    logic [FU_W-1:0]   row_fu;
    logic [TAG_W-1:0]  row_t1, row_t2;
    logic [OP_W-1:0]   row_op;
    logic              wb_en;
    logic [TAG_W-1:0]  wb_tag;
    logic              iss_valid;
    logic [FU_W-1:0]   iss_fu;
    logic [OP_W-1:0]   iss_op;
    logic              iss_ready;
    logic [NUM_FU-1:0] busy;
    logic              disp_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    fust_s_issue #(.NUM_FU(NUM_FU), .OP_W(OP_W)) dut (
        .CLK(CLK), .RST(RST),
        .row_en(row_en), .row_fu(row_fu), .row_t1(row_t1), .row_t2(row_t2), .row_op(row_op),
        .wb_en(wb_en), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_op(iss_op), .iss_ready(iss_ready),
        .busy(busy), .disp_err(disp_err)
    );

    always #5 CLK = ~CLK;

    // Reference model: table of rows plus the single issue slot.
    bit          m_busy [NUM_FU];
    bit          m_r1   [NUM_FU];
    bit          m_r2   [NUM_FU];
    int          m_t1   [NUM_FU];
    int          m_t2   [NUM_FU];
    logic [31:0] m_op   [NUM_FU];
    bit          m_v;
    int          m_fu;
    logic [31:0] m_iop;
    int          m_rr;
    bit          m_err;

    always @(posedge CLK) begin
        bit acc, hs;
        int from, pick, j;
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                m_busy[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_op[i] = 0;
            end
            m_v = 0; m_fu = 0; m_iop = 0; m_rr = 0; m_err = 0;
        end else begin
            acc  = row_en && (int'(row_fu) < NUM_FU) && !m_busy[row_fu];
            hs   = m_v && iss_ready;
            from = hs ? (m_fu + 1) % NUM_FU : m_rr;
            pick = -1;
            for (int k = 0; k < NUM_FU; k++) begin
                j = (from + k) % NUM_FU;
                if (pick < 0 && m_busy[j] && m_r1[j] && m_r2[j] && !(m_v && m_fu == j)) pick = j;
            end
            m_err = row_en && !acc;
            if (wb_en && wb_tag != 0) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (m_busy[i] && m_t1[i] == int'(wb_tag)) m_r1[i] = 1;
                    if (m_busy[i] && m_t2[i] == int'(wb_tag)) m_r2[i] = 1;
                end
            end
            if (acc) begin
                m_busy[row_fu] = 1;
                m_op[row_fu]   = row_op;
                m_t1[row_fu]   = int'(row_t1);
                m_t2[row_fu]   = int'(row_t2);
                m_r1[row_fu]   = (row_t1 == 0) || (wb_en && wb_tag == row_t1);
                m_r2[row_fu]   = (row_t2 == 0) || (wb_en && wb_tag == row_t2);
            end
            if (hs) begin
                m_busy[m_fu] = 0; m_r1[m_fu] = 0; m_r2[m_fu] = 0;
                m_rr = (m_fu + 1) % NUM_FU;
            end
            if (!m_v || hs) begin
                if (pick >= 0) begin
                    m_v = 1; m_fu = pick; m_iop = m_op[pick];
                end else begin
                    m_v = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [NUM_FU-1:0] mb;
        if (chk_on) begin
            for (int i = 0; i < NUM_FU; i++) mb[i] = m_busy[i];
            chk("model_iss_valid", 64'(iss_valid), 64'(m_v));
            if (m_v) begin
                chk("model_iss_fu", 64'(iss_fu), 64'(m_fu));
                chk("model_iss_op", 64'(iss_op), 64'(m_iop));
            end
            chk("model_busy", 64'(busy), 64'(mb));
            chk("model_disp_err", 64'(disp_err), 64'(m_err));
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic disp(input int fu, input int t1, input int t2, input logic [31:0] op);
        row_en = 1'b1;
        row_fu = FU_W'(fu);
        row_t1 = TAG_W'(t1);
        row_t2 = TAG_W'(t2);
        row_op = op;
    endtask

    initial begin
        RST = 1'b1; row_en = 0; row_fu = 0; row_t1 = 0; row_t2 = 0; row_op = 0;
        wb_en = 0; wb_tag = 0; iss_ready = 0;
        @(negedge CLK);
        repeat (3) tick();
        RST = 1'b0;
        chk_on = 1'b1;
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_valid", 64'(iss_valid), 64'h0);
        chk("reset_err", 64'(disp_err), 64'h0);

        // Ready row issues two edges after dispatch.
        disp(2, 0, 0, 32'hA5);
        tick(); row_en = 0;
        chk("lat_busy", 64'(busy), 64'h4);
        chk("lat_valid_early", 64'(iss_valid), 64'h0);
        tick();
        chk("lat_valid", 64'(iss_valid), 64'h1);
        chk("lat_fu", 64'(iss_fu), 64'h2);
        chk("lat_op", 64'(iss_op), 64'hA5);
        iss_ready = 1; tick(); iss_ready = 0;
        chk("lat_busy_clr", 64'(busy), 64'h0);
        chk("lat_idle", 64'(iss_valid), 64'h0);

        // Wakeup by broadcast of tag 3.
        disp(1, 3, 0, 32'h11);
        tick(); row_en = 0;
        tick(); tick();
        chk("wake_wait", 64'(iss_valid), 64'h0);
        wb_en = 1; wb_tag = 3; tick(); wb_en = 0; wb_tag = 0;
        chk("wake_no_issue_yet", 64'(iss_valid), 64'h0);
        tick();
        chk("wake_valid", 64'(iss_valid), 64'h1);
        chk("wake_fu", 64'(iss_fu), 64'h1);
        iss_ready = 1; tick(); iss_ready = 0;

        // Bring rr back to 0 by issuing row 3, then round-robin 0,1,3.
        disp(3, 0, 0, 32'h33); tick(); row_en = 0; tick();
        chk("rr_prep_fu", 64'(iss_fu), 64'h3);
        iss_ready = 1; tick(); iss_ready = 0;
        disp(0, 0, 0, 32'h100); tick();
        disp(1, 0, 0, 32'h101); tick();
        disp(3, 0, 0, 32'h103); tick(); row_en = 0;
        chk("rr_first", 64'(iss_fu), 64'h0);
        iss_ready = 1;
        tick(); chk("rr_second", 64'(iss_fu), 64'h1);
        tick(); chk("rr_third", 64'(iss_fu), 64'h3);
                chk("rr_third_op", 64'(iss_op), 64'h103);
        tick(); chk("rr_drain", 64'(iss_valid), 64'h0);
        iss_ready = 0;
        // rr is 0 now: rows 1 and 3 woken together must pick row 1 first.
        disp(1, 3, 0, 32'h201); tick();
        disp(3, 3, 0, 32'h203); tick(); row_en = 0;
        wb_en = 1; wb_tag = 3; tick(); wb_en = 0; wb_tag = 0;
        tick(); chk("rr_end_pick", 64'(iss_fu), 64'h1);
        iss_ready = 1; tick();
        chk("rr_end_next", 64'(iss_fu), 64'h3);
        tick(); iss_ready = 0;

        // Dispatch to busy row, stall, and dispatch during handshake.
        disp(1, 0, 0, 32'h55); tick();
        disp(1, 0, 0, 32'h66); tick(); row_en = 0;
        chk("err_pulse", 64'(disp_err), 64'h1);
        chk("err_op_kept", 64'(iss_op), 64'h55);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_op", 64'(iss_op), 64'h55);
            chk("stall_err_low", 64'(disp_err), 64'h0);
        end
        iss_ready = 1; disp(1, 0, 0, 32'h77); tick(); iss_ready = 0; row_en = 0;
        chk("hs_err", 64'(disp_err), 64'h1);
        chk("hs_busy", 64'(busy), 64'h0);

        // Simultaneous dispatch and wakeup of different rows.
        disp(0, 2, 0, 32'h300); tick();
        disp(2, 2, 0, 32'h302); wb_en = 1; wb_tag = 2; tick();
        row_en = 0; wb_en = 0; wb_tag = 0;
        chk("sim_busy", 64'(busy), 64'h5);
        tick(); chk("sim_fu", 64'(iss_fu), 64'h2);
        iss_ready = 1; tick(); chk("sim_fu2", 64'(iss_fu), 64'h0);
        tick(); iss_ready = 0;
        chk("sim_idle", 64'(iss_valid), 64'h0);
        // A zero-tag broadcast wakes nothing.
        disp(3, 2, 0, 32'h403); tick(); row_en = 0;
        wb_en = 1; wb_tag = 0; tick(); wb_en = 0; tick();
        chk("tag0_ignored", 64'(iss_valid), 64'h0);

        // Reset while holding with three rows busy.
        disp(0, 0, 0, 32'h500); tick();
        disp(1, 0, 0, 32'h501); tick(); row_en = 0;
        chk("rst_pre_busy", 64'(busy), 64'hB);
        chk("rst_pre_valid", 64'(iss_valid), 64'h1);
        RST = 1; tick(); RST = 0;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_valid", 64'(iss_valid), 64'h0);
        repeat (3) tick();
        chk("rst_quiet", 64'(iss_valid), 64'h0);
        disp(2, 0, 0, 32'h602); tick(); row_en = 0; tick();
        chk("rst_new_fu", 64'(iss_fu), 64'h2);
        chk("rst_new_op", 64'(iss_op), 64'h602);
        iss_ready = 1; tick(); iss_ready = 0; tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fust_s_issue.md
FUST_S_ISSUE -- requirements
Module: fust_s_issue

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning the number of scalar functional-unit rows tracked.
REQ-002 SHALL have parameter OP_W, default 32, meaning the width of the per-row instruction payload.
REQ-003 SHALL derive FU_W = max(1, clog2(NUM_FU)) and TAG_W = clog2(NUM_FU+1); tag 0 means "operand ready", tag k>0 means "produced by FU k-1".
REQ-004 SHALL have one clock and a synchronous, active-high reset: CLK in 1 (all state updates on the rising edge); RST in 1.
REQ-005 SHALL have port row_en in 1: dispatch writes one row this cycle.
REQ-006 SHALL have port row_fu in FU_W: target row index.
REQ-007 SHALL have ports row_t1 and row_t2, each in TAG_W: producer tags of source 1 and source 2.
REQ-008 SHALL have port row_op in OP_W: instruction payload.
REQ-009 SHALL have port wb_en in 1: a writeback broadcast is valid this cycle.
REQ-010 SHALL have port wb_tag in TAG_W: tag being broadcast.
REQ-011 SHALL have port iss_valid out 1: an issue candidate is presented.
REQ-012 SHALL have port iss_fu out FU_W: row being issued.
REQ-013 SHALL have port iss_op out OP_W: payload of the issued row.
REQ-014 SHALL have port iss_ready in 1: the downstream FU accepts.
REQ-015 SHALL have port busy out NUM_FU: per-row occupancy, used by dispatch to stall.
REQ-016 SHALL have port disp_err out 1: one-cycle pulse when a dispatch is rejected.

Function
REQ-017 SHALL keep per-row registers busy, op, t1, t2, rdy1, rdy2, plus a round-robin pointer rr (FU_W) and an output register (iss_valid, iss_fu, iss_op).
REQ-018 SHALL accept row_en only when busy[row_fu]=0 and row_fu<NUM_FU; on accept it SHALL set busy and store op/t1/t2, with rdyN = (tN==0) | (wb_en & wb_tag==tN & tN!=0).
REQ-019 SHALL reject row_en to a busy or out-of-range row with no state change, and SHALL raise disp_err on the following cycle for exactly one cycle.
REQ-020 SHALL, on wb_en with wb_tag!=0, set rdyN in every busy row whose tN equals wb_tag; wb_tag==0 SHALL be ignored.
REQ-021 SHALL define eligible[i] = busy[i] & rdy1[i] & rdy2[i] & ~(iss_valid & iss_fu==i).
REQ-022 SHALL select among eligible rows the first index at or after rr, wrapping modulo NUM_FU.
REQ-023 SHALL operate the output register as two states, IDLE (iss_valid=0) and HOLD (iss_valid=1).
REQ-024 IDLE -> HOLD: when any row is eligible, load the selected row into iss_fu/iss_op.
REQ-025 HOLD -> HOLD or IDLE: on iss_ready, clear busy/rdy of iss_fu, set rr = (iss_fu+1) mod NUM_FU, and load the next eligible row in the same edge if one exists (remain HOLD), else go to IDLE.
REQ-026 In HOLD with iss_ready=0, iss_fu and iss_op SHALL remain stable.
REQ-027 Minimum latency SHALL be: row accepted with both operands ready at edge N -> iss_valid=1 after edge N+1.
REQ-028 A row is busy until its handshake edge, so a dispatch to that row in the handshake cycle SHALL be rejected per REQ-019.
REQ-029 Simultaneous dispatch and wakeup of different rows SHALL both take effect; wakeup SHALL not alter non-busy rows.

Reset
REQ-030 While RST=1 at a rising edge, all busy, rdy1, rdy2, t1, t2 and op bits, rr, iss_valid, iss_fu, iss_op and disp_err SHALL become 0, overriding all other inputs.
REQ-031 Reset asserted in HOLD SHALL drop iss_valid the next cycle with no busy bit remaining set.

Verification
REQ-032 Dispatch row 2 with t1=0, t2=0, op=0xA5 at cycle 0 -> iss_valid=1, iss_fu=2, iss_op=0xA5 at cycle 2; iss_ready=1 -> busy[2]=0 next cycle.
REQ-033 Dispatch row 1 with t1=3, t2=0; wb_tag=3 broadcast at cycle 4 -> no issue before cycle 5, and iss_valid=1 with iss_fu=1 at cycle 6.
REQ-034 Rows 0, 1 and 3 ready with rr=0 and iss_ready held at 1 -> issue order 0, 1, 3 on consecutive cycles; rr ends at 0.
REQ-035 Dispatch to busy row 1 -> disp_err=1 for one cycle and row 1 payload unchanged; then hold iss_ready=0 for 5 cycles -> iss_op stable throughout.
REQ-036 Assert RST for one cycle while in HOLD with 3 rows busy -> busy=0 and iss_valid=0 next cycle; no issue until a new dispatch.
